// File: rtl/counter_reader_pkg.sv
// Shared definitions for the counter read-out requester: controller state codes,
// default geometry and the reader FSM encoding.
package counter_reader_pkg;

    localparam logic [3:0] ST_RESET  = 4'b0001;
    localparam logic [3:0] ST_INIT   = 4'b0010;
    localparam logic [3:0] ST_IDLE   = 4'b0100;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;

    localparam int NUM_CNT_DEF   = 5;
    localparam int DATA_W_DEF    = 8;
    localparam int IDX_W_DEF     = 3;
    localparam int STALL_MAX_DEF = 15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEEK = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } rd_state_e;

endpackage

// File: rtl/next_idx_sel.sv
// Priority search: lowest enabled counter index at or above the scan pointer.
module next_idx_sel #(
    parameter int NUM_CNT = 5,
    parameter int IDX_W   = 3,
    parameter int PTR_W   = 4
) (
    input  logic [NUM_CNT-1:0] mask_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   next_o
);

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        found_o = 1'b0;
        next_o  = '0;
        // Walk downwards so the last hit, the lowest index, wins.
        for (int i = NUM_CNT - 1; i >= 0; i--) begin
            if (mask_i[i] && (i >= int'(ptr_i))) begin
                found_o = 1'b1;
                next_o  = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/counter_reader.sv
// Requester side of the counter read-out port: walks the enabled counters in
// ascending order, one req/capture per counter, and packs the results.
module counter_reader
    import counter_reader_pkg::*;
#(
    parameter int NUM_CNT   = NUM_CNT_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic [3:0]                state,
    input  logic                      start,
    input  logic [NUM_CNT-1:0]        mask,
    input  logic [DATA_W-1:0]         data,
    input  logic                      valid,
    output logic                      req,
    output logic [IDX_W-1:0]          idx,
    output logic [NUM_CNT*DATA_W-1:0] snapshot,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int PTR_W   = IDX_W + 1;
    localparam int STALL_W = $clog2(STALL_MAX + 1);

    rd_state_e                 state_q, state_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_CNT-1:0]        mask_q, mask_d;
    logic [NUM_CNT*DATA_W-1:0] snap_q, snap_d;
    logic [STALL_W-1:0]        stall_q, stall_d;
    logic                      err_q, err_d;
    logic                      done_q;
    logic                      req_d;
    logic                      sel_found;
    logic [IDX_W-1:0]          sel_next;

    next_idx_sel #(
        .NUM_CNT (NUM_CNT),
        .IDX_W   (IDX_W),
        .PTR_W   (PTR_W)
    ) u_next_idx_sel (
        .mask_i  (mask_q),
        .ptr_i   (ptr_q),
        .found_o (sel_found),
        .next_o  (sel_next)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        snap_d  = snap_q;
        stall_d = stall_q;
        err_d   = err_q;
        req_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = mask;
                    err_d   = 1'b0;
                    ptr_d   = '0;
                    stall_d = '0;
                    // An all-zero latched mask falls straight through the search to S_DONE.
                    state_d = S_SEEK;
                end
            end
            S_SEEK: begin
                if (sel_found) begin
                    ptr_d   = {1'b0, sel_next};
                    idx_d   = sel_next;
                    state_d = S_REQ;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_REQ: begin
                if (state == ST_IDLE) begin
                    req_d   = 1'b1;
                    stall_d = '0;
                    state_d = S_WAIT;
                end else if ((stall_q + STALL_W'(1)) == STALL_W'(STALL_MAX)) begin
                    err_d   = 1'b1;
                    stall_d = '0;
                    state_d = S_DONE;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            S_WAIT: begin
                // valid is level-held by the mux; only this sample belongs to our request.
                if (valid) begin
                    snap_d[int'(idx_q)*DATA_W +: DATA_W] = data;
                end else begin
                    err_d = 1'b1;
                end
                ptr_d   = ptr_q + PTR_W'(1);
                state_d = S_SEEK;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
            // NOTE: the snapshot bank is reset so a read before the first scan returns zeros.
            snap_q  <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            snap_q  <= snap_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            done_q  <= (state_d == S_DONE);
        end
    end

    // req must coincide with an idle controller in the same cycle, so it is decoded.
    assign req      = req_d;
    assign idx      = idx_q;
    assign snapshot = snap_q;
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_counter_reader.sv
// Directed bench for counter_reader: a behavioural counter mux answers requests,
// and each step compares DUT outputs against hand-computed values.
module tb_counter_reader;
    import counter_reader_pkg::*;

    localparam int NUM_CNT = 5;
    localparam int DATA_W  = 8;
    localparam int IDX_W   = 3;

    logic                      clk = 1'b0;
    logic                      reset_L;
    logic [3:0]                state;
    logic                      start;
    logic                      start_s;
    logic [NUM_CNT-1:0]        mask;
    logic [DATA_W-1:0]         data = '0;
    logic                      valid = 1'b1;

    logic                      req, req_s;
    logic [IDX_W-1:0]          idx, idx_s;
    logic [NUM_CNT*DATA_W-1:0] snapshot, snapshot_s;
    logic                      busy, busy_s, done, done_s, err, err_s;

    logic [DATA_W-1:0]         cnt [8];
    logic                      bad_en;
    logic [IDX_W-1:0]          bad_idx;

    logic [IDX_W-1:0]          req_log [$];
    int                        reqs_n = 0;
    int                        done_n = 0;
    int                        checks = 0;
    int                        errors = 0;
    int                        cyc = 0;
    int                        n0, d0, s0;

    always #5 clk = ~clk;

    counter_reader #(.NUM_CNT(NUM_CNT), .DATA_W(DATA_W), .IDX_W(IDX_W), .STALL_MAX(15)) dut (
        .clk(clk), .reset_L(reset_L), .state(state), .start(start), .mask(mask),
        .data(data), .valid(valid), .req(req), .idx(idx), .snapshot(snapshot),
        .busy(busy), .done(done), .err(err)
    );

    counter_reader #(.NUM_CNT(NUM_CNT), .DATA_W(DATA_W), .IDX_W(IDX_W), .STALL_MAX(4)) dut_s (
        .clk(clk), .reset_L(reset_L), .state(state), .start(start_s), .mask(mask),
        .data(data), .valid(valid), .req(req_s), .idx(idx_s), .snapshot(snapshot_s),
        .busy(busy_s), .done(done_s), .err(err_s)
    );

    // Counter mux: registers the addressed value on a request and holds it.
    always @(posedge clk) begin
        if (req) begin
            data  <= cnt[idx];
            valid <= !(bad_en && (idx == bad_idx));
        end
    end

    always @(negedge clk) begin
        if (req) req_log.push_back(idx);
        if (req_s) reqs_n <= reqs_n + 1;
        if (done) done_n <= done_n + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_scan(input logic [NUM_CNT-1:0] m);
        mask  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic wait_done();
        while (!done && cyc < 60) tick();
    endtask

    task automatic set_cnt(input logic [39:0] v);
        for (int i = 0; i < NUM_CNT; i++) cnt[i] = v[i*8 +: 8];
    endtask

    initial begin
        reset_L = 1'b0;
        state   = ST_RESET;
        start   = 1'b0;
        start_s = 1'b0;
        mask    = '0;
        bad_en  = 1'b0;
        bad_idx = '0;
        for (int i = 0; i < 8; i++) cnt[i] = '0;
        tick();
        tick();
        check("rst_req", req, 0);
        check("rst_idx", idx, 0);
        check("rst_snapshot", snapshot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset_L = 1'b1;
        state   = ST_INIT;
        tick();
        state   = ST_IDLE;
        tick();

        // Full scan
        set_cnt(40'h5544332211);
        n0 = req_log.size();
        start_scan(5'b11111);
        check("full_busy", busy, 1);
        wait_done();
        check("full_done_cycle", cyc, 17);
        check("full_busy_at_done", busy, 0);
        check("full_snapshot", snapshot, 40'h5544332211);
        check("full_err", err, 0);
        tick();
        check("full_done_pulse", done, 0);
        check("full_req_count", req_log.size() - n0, 5);
        for (int i = 0; i < 5; i++) check("full_req_idx", req_log[n0 + i], i);

        // Sparse mask
        set_cnt(40'hA5A4A3A2A1);
        n0 = req_log.size();
        start_scan(5'b10010);
        wait_done();
        check("sparse_done_cycle", cyc, 8);
        check("sparse_snapshot", snapshot, 40'hA5443_3A211);
        tick();
        check("sparse_req_count", req_log.size() - n0, 2);
        check("sparse_req_idx0", req_log[n0], 1);
        check("sparse_req_idx1", req_log[n0 + 1], 4);

        // Stall below the limit
        set_cnt(40'h000000005A);
        state = ST_ACTIVE;
        n0 = req_log.size();
        start_scan(5'b00001);
        repeat (6) tick();
        check("stall_no_req", req, 0);
        check("stall_busy", busy, 1);
        tick();
        state = ST_IDLE;
        #1;
        check("stall_req_fires", req, 1);
        wait_done();
        check("stall_done_cycle", cyc, 11);
        check("stall_err", err, 0);
        check("stall_snapshot", snapshot, 40'hA54433A25A);
        tick();
        check("stall_req_count", req_log.size() - n0, 1);

        // Stall timeout on the STALL_MAX=4 instance
        state   = ST_ACTIVE;
        mask    = 5'b00001;
        s0      = reqs_n;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        cyc     = 1;
        while (!done_s && cyc < 60) tick();
        check("timeout_done_cycle", cyc, 6);
        check("timeout_err", err_s, 1);
        check("timeout_busy", busy_s, 0);
        tick();
        check("timeout_no_req", reqs_n - s0, 0);
        check("timeout_snapshot", snapshot_s, 0);
        state = ST_IDLE;
        tick();

        // Missing valid on idx 2
        set_cnt(40'h6564636261);
        bad_en  = 1'b1;
        bad_idx = 3'd2;
        n0 = req_log.size();
        start_scan(5'b11111);
        wait_done();
        check("miss_done_cycle", cyc, 17);
        check("miss_err", err, 1);
        check("miss_snapshot", snapshot, 40'h6564336261);
        tick();
        bad_en = 1'b0;
        check("miss_err_sticky", err, 1);
        check("miss_req_count", req_log.size() - n0, 5);
        check("miss_last_idx", req_log[req_log.size() - 1], 4);

        // Reset during S_WAIT of idx 1
        set_cnt(40'h7574737271);
        start_scan(5'b11111);
        check("err_cleared_on_start", err, 0);
        repeat (5) tick();
        check("mid_scan_snapshot", snapshot, 40'h6564336271);
        d0 = done_n;
        reset_L = 1'b0;
        tick();
        check("mid_rst_req", req, 0);
        check("mid_rst_idx", idx, 0);
        check("mid_rst_snapshot", snapshot, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        reset_L = 1'b1;
        repeat (20) tick();
        check("mid_rst_no_done", done_n - d0, 0);
        start_scan(5'b11111);
        wait_done();
        check("post_rst_done_cycle", cyc, 17);
        check("post_rst_snapshot", snapshot, 40'h7574737271);
        check("post_rst_err", err, 0);
        tick();

        // Start while busy, start on done, then empty mask
        set_cnt(40'h8584838281);
        d0 = done_n;
        start_scan(5'b11111);
        repeat (3) tick();
        mask  = 5'b00001;
        start = 1'b1;
        tick();
        start = 1'b0;
        mask  = 5'b11111;
        wait_done();
        check("busy_start_done_cycle", cyc, 17);
        check("busy_start_snapshot", snapshot, 40'h8584838281);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_on_done_dropped", busy, 0);
        check("start_on_done_no_done", done, 0);
        check("busy_start_single_done", done_n - d0, 1);
        n0 = req_log.size();
        start_scan(5'b00000);
        check("empty_busy", busy, 1);
        wait_done();
        check("empty_done_cycle", cyc, 2);
        tick();
        check("empty_no_req", req_log.size() - n0, 0);
        check("empty_snapshot", snapshot, 40'h8584838281);
        check("empty_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
